// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte output bundle for uart_rx
interface uart_rx_if;
   logic       rx_clk_en;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_active;

   modport master (
      input  rx_clk_en,
      input  uart_rx,
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_active
   );

   modport slave (
      output rx_clk_en,
      output uart_rx,
      input  rx_data,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_active
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with framing-error and break handling
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        rst,
   uart_rx_if.master  bus
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      STOP       = 3'd3,
      BREAK_WAIT = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;

   state_t        state, state_n;
   logic [CW-1:0] tick_cnt, tick_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic [7:0]    data_q, data_n;
   logic          valid_q, valid_n;
   logic          ferr_q, ferr_n;
   logic          active;

   // Metastability synchroniser on the raw line; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.uart_rx};
      end
   end

   assign rx_s = sync[SYNC_STAGES-1];

   // State, counters and output registers; pulses fall back to 0 on any clk since next-value defaults are 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         ferr_q   <= ferr_n;
      end
   end

   // Next-state and datapath decisions, taken only on oversampling ticks.
   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      bit_n   = bit_idx;
      shift_n = shift;
      data_n  = data_q;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      active  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_clk_en && !rx_s) begin
               state_n = START;
               tick_n  = '0;
            end
         end
         START: begin
            active = 1'b1;
            if (bus.rx_clk_en) begin
               if (tick_cnt == HALF_LAST) begin
                  tick_n = '0;
                  if (!rx_s) begin
                     state_n = DATA;
                     bit_n   = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            active = 1'b1;
            if (bus.rx_clk_en) begin
               if (tick_cnt == FULL_LAST) begin
                  shift_n[bit_idx] = rx_s;
                  tick_n           = '0;
                  if (bit_idx == 3'd7) begin
                     state_n = STOP;
                  end else begin
                     bit_n = bit_idx + 3'd1;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            active = 1'b1;
            if (bus.rx_clk_en) begin
               if (tick_cnt == FULL_LAST) begin
                  data_n = shift;
                  tick_n = '0;
                  if (rx_s) begin
                     valid_n = 1'b1;
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = BREAK_WAIT;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         BREAK_WAIT: begin
            if (bus.rx_clk_en && rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            tick_n  = '0;
            bit_n   = '0;
         end
      endcase
   end

   // Drive the output bundle from the registered results and the current state.
   always_comb begin
      bus.rx_data      = data_q;
      bus.rx_valid     = valid_q;
      bus.rx_frame_err = ferr_q;
      bus.rx_active    = active;
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

   logic clk;
   logic rst;
   uart_rx_if bus ();

   uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp;
   int n_bad;

   int div;
   int tick_ph;
   int cyc;
   int fall_cyc;
   int valid_cnt;
   int ferr_cnt;
   int both_cnt;
   int active_cnt;
   int valid_cyc;
   int prev_valid_cyc;
   logic [7:0] rxq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oversampling tick: one clk in every div clocks.
   initial begin
      bus.rx_clk_en = 1'b0;
      tick_ph = 0;
      forever begin
         @(negedge clk);
         tick_ph = (tick_ph + 1) % div;
         bus.rx_clk_en = (tick_ph == 0);
      end
   end

   // Record DUT output events on the falling edge.
   initial begin
      cyc = 0;
      valid_cnt = 0;
      ferr_cnt = 0;
      both_cnt = 0;
      active_cnt = 0;
      valid_cyc = 0;
      prev_valid_cyc = 0;
      forever begin
         @(negedge clk);
         if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            prev_valid_cyc = valid_cyc;
            valid_cyc = cyc;
            rxq.push_back(bus.rx_data);
         end
         if (bus.rx_frame_err === 1'b1) ferr_cnt++;
         if (bus.rx_valid === 1'b1 && bus.rx_frame_err === 1'b1) both_cnt++;
         if (bus.rx_active === 1'b1) active_cnt++;
         cyc++;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic idle(input int n);
      bus.uart_rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int cpb);
      bus.uart_rx = b;
      repeat (cpb) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb);
      fall_cyc = cyc;
      drive_bit(1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
      drive_bit(stop_bit, cpb);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
      n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
      n_cmp++; if (bus.rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", bus.rx_frame_err); end
      n_cmp++; if (bus.rx_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", bus.rx_active); end
      rst = 1'b0;
      idle(20);
   endtask

   task automatic test_nominal();
      int v0, f0, a0, lat;
      v0 = valid_cnt; f0 = ferr_cnt; a0 = active_cnt;
      send_frame(8'hA5, 1'b1, 16);
      idle(16);
      lat = valid_cyc - fall_cyc;
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL nominal_valid_count: got %0d want 1", valid_cnt - v0); end
      n_cmp++; if (bus.rx_data !== 8'hA5) begin n_bad++; $display("FAIL nominal_data: got %h want a5", bus.rx_data); end
      n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL nominal_ferr: got %0d want 0", ferr_cnt - f0); end
      n_cmp++; if (lat < 149 || lat > 155) begin n_bad++; $display("FAIL nominal_latency: got %0d want 149..155", lat); end
      n_cmp++; if (active_cnt - a0 < 150 || active_cnt - a0 > 154) begin n_bad++; $display("FAIL nominal_active_window: got %0d want 150..154", active_cnt - a0); end
      n_cmp++; if (bus.rx_active !== 1'b0) begin n_bad++; $display("FAIL nominal_active_end: got %b want 0", bus.rx_active); end
   endtask

   task automatic test_glitch();
      int v0, f0, a0;
      v0 = valid_cnt; f0 = ferr_cnt; a0 = active_cnt;
      drive_bit(1'b0, 4);
      idle(40);
      n_cmp++; if (active_cnt - a0 < 6 || active_cnt - a0 > 10) begin n_bad++; $display("FAIL glitch_active: got %0d want 6..10", active_cnt - a0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
      n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
      n_cmp++; if (bus.rx_data !== 8'hA5) begin n_bad++; $display("FAIL glitch_data: got %h want a5", bus.rx_data); end
      n_cmp++; if (bus.rx_active !== 1'b0) begin n_bad++; $display("FAIL glitch_active_end: got %b want 0", bus.rx_active); end
   endtask

   task automatic test_frame_err_break();
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 16);
      drive_bit(1'b0, 40 * 16);
      idle(32);
      n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL break_ferr_count: got %0d want 1", ferr_cnt - f0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL break_valid: got %0d want 0", valid_cnt - v0); end
      n_cmp++; if (bus.rx_data !== 8'h3C) begin n_bad++; $display("FAIL break_data: got %h want 3c", bus.rx_data); end
      send_frame(8'h11, 1'b1, 16);
      idle(16);
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL after_break_valid: got %0d want 1", valid_cnt - v0); end
      n_cmp++; if (bus.rx_data !== 8'h11) begin n_bad++; $display("FAIL after_break_data: got %h want 11", bus.rx_data); end
      n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL after_break_ferr: got %0d want 1", ferr_cnt - f0); end
   endtask

   task automatic test_back_to_back();
      int v0, gap;
      v0 = valid_cnt;
      rxq.delete();
      send_frame(8'h00, 1'b1, 16);
      send_frame(8'hFF, 1'b1, 16);
      idle(16);
      gap = valid_cyc - prev_valid_cyc;
      n_cmp++; if (valid_cnt - v0 !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
      n_cmp++; if (gap < 157 || gap > 163) begin n_bad++; $display("FAIL b2b_gap: got %0d want 157..163", gap); end
      if (rxq.size() == 2) begin
         n_cmp++; if (rxq[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_first: got %h want 00", rxq[0]); end
         n_cmp++; if (rxq[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got %h want ff", rxq[1]); end
      end else begin
         n_cmp++; n_bad++; $display("FAIL b2b_queue: got %0d bytes want 2", rxq.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      logic [7:0] d;
      d = 8'h77;
      v0 = valid_cnt;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
      drive_bit(d[3], 8);
      n_cmp++; if (bus.rx_active !== 1'b1) begin n_bad++; $display("FAIL midrst_active_before: got %b want 1", bus.rx_active); end
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      #1;
      n_cmp++; if (bus.rx_active !== 1'b0) begin n_bad++; $display("FAIL midrst_active: got %b want 0", bus.rx_active); end
      n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", bus.rx_data); end
      n_cmp++; if (bus.rx_valid !== 1'b0 || bus.rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_pulses: got %b%b want 00", bus.rx_valid, bus.rx_frame_err); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(16 * 12);
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL midrst_no_pulse: got %0d want 0", valid_cnt - v0); end
      send_frame(8'h5A, 1'b1, 16);
      idle(16);
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL midrst_next_valid: got %0d want 1", valid_cnt - v0); end
      n_cmp++; if (bus.rx_data !== 8'h5A) begin n_bad++; $display("FAIL midrst_next_data: got %h want 5a", bus.rx_data); end
   endtask

   task automatic test_sparse_tick();
      int v0;
      v0 = valid_cnt;
      div = 4;
      idle(64);
      send_frame(8'h81, 1'b1, 64);
      idle(64);
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL sparse_valid: got %0d want 1", valid_cnt - v0); end
      n_cmp++; if (bus.rx_data !== 8'h81) begin n_bad++; $display("FAIL sparse_data: got %h want 81", bus.rx_data); end
      div = 1;
      idle(32);
   endtask

   task automatic test_loopback();
      int f0;
      logic [7:0] exp_b;
      f0 = ferr_cnt;
      rxq.delete();
      for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 16);
      idle(32);
      n_cmp++; if (rxq.size() !== 256) begin n_bad++; $display("FAIL loop_count: got %0d want 256", rxq.size()); end
      n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL loop_ferr: got %0d want 0", ferr_cnt - f0); end
      for (int b = 0; b < rxq.size() && b < 256; b++) begin
         exp_b = 8'(b);
         n_cmp++; if (rxq[b] !== exp_b) begin n_bad++; $display("FAIL loop_byte[%0d]: got %h want %h", b, rxq[b], exp_b); end
      end
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL exclusive: got %0d overlaps want 0", both_cnt); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      div = 1;
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      test_reset();
      test_nominal();
      test_glitch();
      test_frame_err_break();
      test_back_to_back();
      test_reset_mid_frame();
      test_sparse_tick();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the team's UART transmitter: deserialises the asynchronous serial line into 8-bit bytes.
- 8N1 framing (1 start, 8 data LSB-first, 1 stop), no parity.
- Runs in the system clock domain; all state advances on an oversampling tick enable (rx_clk_en) from the shared baud generator, OVERSAMPLE ticks per bit.
- Feeds received bytes to downstream logic (RX FIFO / register block) as a one-cycle valid pulse; reports framing errors.

Parameters:
- OVERSAMPLE, 16: rx_clk_en ticks per bit period; even, >= 4.
- SYNC_STAGES, 2: flops in the input synchroniser; >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- rx_clk_en  input  1  oversampling tick, one clk wide, OVERSAMPLE per bit.
- uart_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte; holds until next frame end.
- rx_valid  output  1  one-clk pulse: rx_data updated, stop bit good.
- rx_frame_err  output  1  one-clk pulse: stop bit sampled low.
- rx_active  output  1  high while a frame is being received.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - Synchroniser flops = 1.
  - rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_active=0.
  - state=IDLE, tick_cnt=0, bit_idx=0, shift register=0x00.
- Synchroniser:
  - uart_rx passes through SYNC_STAGES flops every clk; it is not gated by rx_clk_en.
  - rx_s is the synchroniser output.
- Advancement: the FSM and counters change only on clk edges where rx_clk_en=1, with one exception: rx_valid and rx_frame_err deassert on the next clk edge regardless of rx_clk_en.
- IDLE:
  - rx_active=0.
  - On a tick with rx_s=0 -> START, tick_cnt=0.
- START:
  - rx_active=1; tick_cnt increments per tick.
  - On the tick where tick_cnt==OVERSAMPLE/2-1, sample rx_s (mid start bit):
    - rx_s=0 -> DATA, tick_cnt=0, bit_idx=0.
    - rx_s=1 -> false start (glitch), return to IDLE with no output pulse.
- DATA:
  - tick_cnt increments per tick.
  - On the tick where tick_cnt==OVERSAMPLE-1 (mid bit): shift register[bit_idx] <= rx_s, tick_cnt=0.
  - If bit_idx==7 -> STOP; else bit_idx+1.
- STOP:
  - On the tick where tick_cnt==OVERSAMPLE-1 (mid stop bit): rx_data <= shift register.
  - rx_s=1 -> rx_valid=1 for one clk, go to IDLE.
  - rx_s=0 -> rx_frame_err=1 for one clk, rx_data still updated, go to BREAK_WAIT.
  - Returning at mid stop bit leaves half a bit of margin to detect the next start edge.
- BREAK_WAIT:
  - rx_active=0.
  - Stay until a tick with rx_s=1, then go to IDLE.
  - A held-low line (break) therefore produces exactly one frame error, not a stream of them.
- Exclusivity: rx_valid and rx_frame_err are never high together.
- rx_active: 1 in START/DATA/STOP, otherwise 0.
- Latency:
  - Start-edge detection occurs SYNC_STAGES clk plus at most one tick after the line falls.
  - rx_valid is asserted about 9.5 bit periods after the start edge.
- Reset mid-frame: immediate abort to the reset values above. A partially received byte is discarded and never presented.
- Unreachable state encodings -> IDLE.

Test Plan:
- Nominal byte: rx_clk_en=1 every clk, OVERSAMPLE=16 (16 clk/bit), send 0xA5 with good stop.
  -> one rx_valid pulse, rx_data=0xA5, rx_frame_err never set.
  -> rx_valid rises 152±3 clk after the line falls; rx_active high for that window.
- Glitch rejection: line low for 4 clk, then high.
  -> rx_active pulses high for about 8 clk, then returns to 0.
  -> no rx_valid or rx_frame_err; rx_data unchanged.
- Framing error and break: send 0x3C with the stop bit low, then hold the line low for 40 bit periods, then release.
  -> exactly one rx_frame_err, rx_data=0x3C, no rx_valid.
  -> after release, send 0x11 -> rx_valid, rx_data=0x11.
- Back-to-back frames: 0x00 then 0xFF, one stop bit each, no idle gap.
  -> two rx_valid pulses 160±3 clk apart; rx_data 0x00 then 0xFF.
- Reset mid-frame: assert rst for 2 clk during data bit 3 of 0x77.
  -> all outputs 0 immediately, no pulse for 0x77.
  -> the next full frame 0x5A gives rx_valid with rx_data=0x5A.
- Sparse tick and loopback:
  - rx_clk_en one clk in four (64 clk/bit): send 0x81 -> rx_valid, rx_data=0x81.
  - Looped back from the transmitter at matching baud, bytes 0x00..0xFF all received in order with no errors.
